tx_pkt_loader: RTL and testbench
================================

Name: tx_pkt_loader

Overview:
- Upstream feeder for the BLE TX serializer.
- Holds a software-written PDU payload buffer (up to 37 bytes) plus a header byte and a length, and pushes the 2-byte PDU header and then the payload into the TX input FIFO, one byte per enabled cycle.
- Pulses txstart, tracks the txready handshake through the whole transmission and reports done or error to the register bank.
- Is the only writer of the TX FIFO.

Parameters:
- MAX_PL, 37, maximum payload bytes; larger lengths saturate to this value.
- AW, 6, payload buffer address width.
- RDY_TIMEOUT, 8, enabled cycles allowed for txready to fall after txstart.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  clock enable; all state, counters and flag updates advance only when en=1.
- pl_we  in  1  payload buffer write strobe (not gated by en).
- pl_waddr  in  AW  payload buffer byte address.
- pl_wdata  in  8  payload buffer write data.
- hdr0  in  8  PDU header byte 0, sent verbatim.
- length  in  6  payload length in bytes.
- send  in  1  start request, level-sampled in IDLE.
- busy  out  1  high from send acceptance to completion.
- done  out  1  one-enabled-cycle pulse when the transmission completes.
- err  out  1  sticky timeout flag; cleared by the next accepted send.
- txdata_out  out  8  byte to the TX FIFO.
- wr_en  out  1  TX FIFO write strobe.
- txstart  out  1  start strobe to the serializer.
- txready  in  1  serializer ready / last transmission done.

Behaviour:
- **Reset values:** busy=0, done=0, err=0, txstart=0, wr_en=0, txdata_out=0x00; state=IDLE; counters=0. Buffer contents are undefined after reset.
- **Payload buffer:** MAX_PL x 8 registers. A write occurs on pl_we when pl_waddr<MAX_PL and busy=0. Writes with busy=1 or an out-of-range address are dropped.
- **Send acceptance:**
  - On accept, len_q = min(length, MAX_PL) and hdr0_q = hdr0 are latched.
  - Inputs are not re-sampled until the next IDLE.
  - err is cleared and busy is set.
- **State machine** (transitions only on en=1):
  - IDLE: if send, go to WAIT_RDY.
  - WAIT_RDY: wait for txready=1 (covers the tail of a previous packet), then go to PUSH_H0.
  - PUSH_H0: drive txdata_out=hdr0_q and go to PUSH_H1.
  - PUSH_H1: drive txdata_out={2'b00,len_q}.
    - If len_q=0, go to START.
    - Otherwise clear idx and go to PUSH_PL.
  - PUSH_PL: drive txdata_out=buf[idx] and increment idx. On idx=len_q-1, go to START.
  - START: drive txstart=1, clear the timeout counter and go to WAIT_BUSY.
  - WAIT_BUSY:
    - If txready=0, go to WAIT_DONE.
    - Otherwise increment the counter. When it reaches RDY_TIMEOUT, set err, drop busy and go to IDLE without a done pulse.
  - WAIT_DONE: on txready=1, pulse done, drop busy and go to IDLE.
- **wr_en** = en AND (state is PUSH_H0, PUSH_H1 or PUSH_PL). It is combinational so that exactly one FIFO write occurs per byte regardless of en gaps.
- **txdata_out** is a combinational state decode and is 0x00 outside the push states.
- **txstart** is a decode of START. It stays high across en=0 cycles until START is left, so the serializer's en-qualified sampler sees exactly one enabled high cycle.
- **Byte count:** total bytes pushed per packet = 2 + len_q, at most 39. The FIFO depth is 39 or more, so no full check is made.
- **send held high:** a send held high after completion starts a new packet from IDLE at the next enabled cycle.
- **send while busy:** ignored.
- **Reset mid-operation:** asynchronous return to IDLE with all outputs at reset values. Partially pushed FIFO bytes are the system's responsibility, because the serializer is reset by the same reset.

Test Plan:
1. Write buffer 0..2 = 0xA1,0xB2,0xC3; set hdr0=0x42, length=3; pulse send with en=1 and txready=1 → wr_en bytes in order 0x42,0x03,0xA1,0xB2,0xC3, then one txstart cycle; drop txready 2 cycles later and raise it after 100 cycles → done pulses once, busy falls and err=0.
2. length=0 → exactly two writes, 0x42 then 0x00, then txstart.
3. length=45 with buffer filled → hdr1=0x25 and 37 payload writes (39 total). A write to pl_waddr=40 leaves the buffer unchanged.
4. en toggling 1,0,1,0 during push → one write per enabled cycle with no duplicated bytes, and txstart is seen high on exactly one en=1 cycle.
5. txready held at 1 after txstart → err=1 after 8 enabled cycles, busy=0 and no done. The next send clears err.
6. Assert rst_n=0 mid-PUSH_PL → all outputs 0 immediately and state IDLE. A pl_we or send pulse during busy is ignored in a separate run.

Source files
------------

// File: rtl/tx_pkt_loader.sv
// tx_pkt_loader: loads PDU header and payload into the BLE TX FIFO, then runs the txstart/txready handshake.
module tx_pkt_loader #(
  parameter int MAX_PL      = 37,
  parameter int AW          = 6,
  parameter int RDY_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          pl_we,
  input  logic [AW-1:0] pl_waddr,
  input  logic [7:0]    pl_wdata,
  input  logic [7:0]    hdr0,
  input  logic [5:0]    length,
  input  logic          send,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    txdata_out,
  output logic          wr_en,
  output logic          txstart,
  input  logic          txready
);
  localparam int CW = $clog2(RDY_TIMEOUT + 1);
  localparam logic [AW-1:0] MAXA = AW'(MAX_PL);
  localparam logic [5:0]    MAXL = 6'(MAX_PL);
  localparam logic [CW-1:0] TO   = CW'(RDY_TIMEOUT);
  typedef enum logic [2:0] {IDLE, WAIT_RDY, PUSH_H0, PUSH_H1, PUSH_PL, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t        state_q, state_d;
  logic [5:0]    len_q, len_d;
  logic [7:0]    hdr0_q, hdr0_d;
  logic [AW-1:0] idx_q, idx_d, last_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, done_q, done_d;
  logic [7:0]    buf_q [MAX_PL];
  assign last_idx = AW'(len_q - 6'd1);
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hdr0_d  = hdr0_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = done_q;
    if (en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: if (send) begin
          state_d = WAIT_RDY;
          len_d   = (length > MAXL) ? MAXL : length;
          hdr0_d  = hdr0;
          err_d   = 1'b0;
        end
        WAIT_RDY: if (txready) state_d = PUSH_H0;
        PUSH_H0:  state_d = PUSH_H1;
        PUSH_H1: begin
          state_d = (len_q == 6'd0) ? START : PUSH_PL;
          idx_d   = '0;
        end
        PUSH_PL: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == last_idx) state_d = START;
        end
        START: begin
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end
        WAIT_BUSY: if (!txready) state_d = WAIT_DONE;
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        WAIT_DONE: if (txready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      hdr0_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hdr0_q  <= hdr0_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end
  // software writes are frozen while a packet is in flight
  always_ff @(posedge clk) begin
    if (pl_we && pl_waddr < MAXA && state_q == IDLE) buf_q[pl_waddr] <= pl_wdata;
  end
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign err     = err_q;
  assign txstart = state_q == START;
  assign wr_en   = en && (state_q inside {PUSH_H0, PUSH_H1, PUSH_PL});
  assign txdata_out = (state_q == PUSH_H0) ? hdr0_q :
                      (state_q == PUSH_H1) ? {2'b00, len_q} :
                      (state_q == PUSH_PL) ? buf_q[idx_q] : 8'h00;
endmodule

// File: tb/tb_tx_pkt_loader.sv
// tb_tx_pkt_loader: directed checks of FIFO byte order, saturation, en gaps, timeout and reset.
module tb_tx_pkt_loader;
  logic       clk = 0, rst_n = 0, en = 1, pl_we = 0, send = 0, txready = 1;
  logic [5:0] pl_waddr = 0, length = 0;
  logic [7:0] pl_wdata = 0, hdr0 = 0;
  logic       busy, done, err, wr_en, txstart;
  logic [7:0] txdata_out;
  int checks = 0, errors = 0;
  int wcount = 0, stcount = 0, dncount = 0;
  logic [7:0] bytes [0:1023];
  int base, sbase, dbase;
  tx_pkt_loader dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pl_we(pl_we), .pl_waddr(pl_waddr),
    .pl_wdata(pl_wdata), .hdr0(hdr0), .length(length), .send(send), .busy(busy),
    .done(done), .err(err), .txdata_out(txdata_out), .wr_en(wr_en),
    .txstart(txstart), .txready(txready)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_en) begin
      bytes[wcount] = txdata_out;
      wcount++;
    end
    if (txstart && en) stcount++;
    if (done) dncount++;
  end
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input int d);
    pl_we = 1; pl_waddr = 6'(a); pl_wdata = 8'(d);
    cyc(1);
    pl_we = 0;
  endtask
  task automatic go(input int h, input int l);
    hdr0 = 8'(h); length = 6'(l); send = 1;
    base = wcount; sbase = stcount; dbase = dncount;
    cyc(1);
    send = 0;
  endtask
  task automatic wait_start(input string tag);
    for (int k = 0; k < 200 && !txstart; k++) cyc(1);
    chk(tag, int'(txstart), 1);
  endtask
  task automatic finish_pkt(input string tag);
    cyc(1);
    txready = 0;
    cyc(3);
    txready = 1;
    for (int k = 0; k < 20 && !done; k++) cyc(1);
    chk(tag, int'(done), 1);
    cyc(1);
  endtask
  initial begin
    cyc(2);
    chk("rst_outs", int'({busy, done, err, txstart, wr_en}), 0);
    chk("rst_data", int'(txdata_out), 0);
    rst_n = 1;
    cyc(1);
    // 1: basic 3-byte packet
    wr(0, 8'hA1); wr(1, 8'hB2); wr(2, 8'hC3);
    go(8'h42, 3);
    chk("t1_busy", int'(busy), 1);
    wait_start("t1_start");
    chk("t1_count", wcount - base, 5);
    chk("t1_b0", int'(bytes[base]), 8'h42);
    chk("t1_b1", int'(bytes[base+1]), 8'h03);
    chk("t1_b2", int'(bytes[base+2]), 8'hA1);
    chk("t1_b3", int'(bytes[base+3]), 8'hB2);
    chk("t1_b4", int'(bytes[base+4]), 8'hC3);
    cyc(2);
    txready = 0;
    cyc(100);
    chk("t1_wait_busy", int'(busy), 1);
    txready = 1;
    for (int k = 0; k < 20 && !done; k++) cyc(1);
    chk("t1_done", int'(done), 1);
    chk("t1_busy_fall", int'(busy), 0);
    cyc(1);
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_err", int'(err), 0);
    chk("t1_starts", stcount - sbase, 1);
    chk("t1_dones", dncount - dbase, 1);
    // 2: zero-length packet
    go(8'h42, 0);
    wait_start("t2_start");
    chk("t2_count", wcount - base, 2);
    chk("t2_b0", int'(bytes[base]), 8'h42);
    chk("t2_b1", int'(bytes[base+1]), 8'h00);
    finish_pkt("t2_done");
    // 3: length saturation, out-of-range write dropped
    for (int i = 0; i < 37; i++) wr(i, i * 3 + 1);
    wr(40, 8'hFF);
    go(8'h42, 45);
    wait_start("t3_start");
    chk("t3_count", wcount - base, 39);
    chk("t3_hdr1", int'(bytes[base+1]), 8'h25);
    for (int i = 0; i < 37; i++) chk($sformatf("t3_pl%0d", i), int'(bytes[base+2+i]), (i * 3 + 1) & 8'hFF);
    finish_pkt("t3_done");
    // 4: en toggling during push
    go(8'h42, 3);
    for (int k = 0; k < 20; k++) begin
      en = k[0];
      cyc(1);
    end
    en = 1;
    chk("t4_count", wcount - base, 5);
    chk("t4_b0", int'(bytes[base]), 8'h42);
    chk("t4_b1", int'(bytes[base+1]), 8'h03);
    chk("t4_b2", int'(bytes[base+2]), 8'h01);
    chk("t4_b3", int'(bytes[base+3]), 8'h04);
    chk("t4_b4", int'(bytes[base+4]), 8'h07);
    chk("t4_starts", stcount - sbase, 1);
    chk("t4_err", int'(err), 0);
    finish_pkt("t4_done");
    // 5: txready never falls -> timeout after 8 enabled cycles
    go(8'h42, 1);
    wait_start("t5_start");
    cyc(8);
    chk("t5_err_early", int'(err), 0);
    cyc(1);
    chk("t5_err", int'(err), 1);
    chk("t5_busy", int'(busy), 0);
    cyc(3);
    chk("t5_no_done", dncount - dbase, 0);
    chk("t5_err_sticky", int'(err), 1);
    go(8'h42, 1);
    chk("t5_err_clr", int'(err), 0);
    chk("t5_busy2", int'(busy), 1);
    wait_start("t5_start2");
    finish_pkt("t5_done2");
    // 6: async reset mid payload push
    go(8'h42, 5);
    for (int k = 0; k < 50 && (wcount - base) < 3; k++) cyc(1);
    rst_n = 0;
    #1;
    chk("t6_rst_outs", int'({busy, done, err, txstart, wr_en}), 0);
    chk("t6_rst_data", int'(txdata_out), 0);
    cyc(1);
    rst_n = 1;
    cyc(1);
    chk("t6_idle", int'(busy), 0);
    // writes and send while busy are ignored
    txready = 0;
    go(8'h42, 1);
    wr(0, 8'h99);
    hdr0 = 8'h55; length = 6'd7; send = 1;
    cyc(1);
    send = 0;
    txready = 1;
    wait_start("t6_start");
    chk("t6_count", wcount - base, 3);
    chk("t6_b0", int'(bytes[base]), 8'h42);
    chk("t6_b1", int'(bytes[base+1]), 8'h01);
    chk("t6_b2", int'(bytes[base+2]), 8'h01);
    finish_pkt("t6_done");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
